// File: rtl/rs232_cmd_bridge_if.sv
// Byte-stream and register-bus signals shared by the command bridge and its neighbours.
// master = the bridge itself; slave = receiver/transmitter/register-bus side.
interface rs232_cmd_bridge_if;
  logic [7:0] rx_data;
  logic       rx_push;
  logic       rx_full;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_rdata;
  logic       reg_ack;

  modport master (
    input  rx_data, rx_push, tx_full, reg_rdata, reg_ack,
    output rx_full, tx_data, tx_push, reg_addr, reg_wdata, reg_write, reg_read
  );

  modport slave (
    output rx_data, rx_push, tx_full, reg_rdata, reg_ack,
    input  rx_full, tx_data, tx_push, reg_addr, reg_wdata, reg_write, reg_read
  );
endinterface

// File: rtl/rs232_cmd_bridge.sv
// ASCII hex peek/poke interpreter: parses W/R lines from the UART receiver, runs one
// register-bus beat, and streams the reply to the UART transmitter.
//   IDLE    | waiting for W/R     ADDR_HI/LO | address nibbles   DATA_HI/LO | write data nibbles
//   EOL     | expecting LF        BUS        | request held       RESP       | draining reply bytes
//   SKIP    | discarding a malformed line until LF
module rs232_cmd_bridge #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  rs232_cmd_bridge_if.master bus
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_ADDR_HI = 4'd1;
  localparam logic [3:0] ST_ADDR_LO = 4'd2;
  localparam logic [3:0] ST_DATA_HI = 4'd3;
  localparam logic [3:0] ST_DATA_LO = 4'd4;
  localparam logic [3:0] ST_EOL     = 4'd5;
  localparam logic [3:0] ST_BUS     = 4'd6;
  localparam logic [3:0] ST_RESP    = 4'd7;
  localparam logic [3:0] ST_SKIP    = 4'd8;

  localparam logic [15:0] TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);
  localparam logic [7:0]  CH_LF = 8'h0A;
  localparam logic [7:0]  CH_CR = 8'h0D;
  localparam logic [7:0]  CH_QM = 8'h3F;
  localparam logic [7:0]  CH_EX = 8'h21;
  localparam logic [7:0]  CH_K  = 8'h4B;

  logic [3:0]  state;
  logic        is_write;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        read_q;
  logic [15:0] bus_cnt;
  logic [23:0] resp_buf;
  logic [1:0]  resp_cnt;
  logic [1:0]  push_hist;
  logic        take;
  logic        byte_lf;
  logic        byte_hex;
  logic [3:0]  byte_nib;

  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    hex_decode = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      hex_decode = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      hex_decode = {1'b1, c[3:0] + 4'd9};
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
  endfunction

  assign {byte_hex, byte_nib} = hex_decode(bus.rx_data);
  assign byte_lf = (bus.rx_data == CH_LF);

  assign bus.rx_full = reset | (state == ST_BUS) | (state == ST_RESP);
  // CR never reaches the parser, so it is transparent in every parsing state
  assign take = bus.rx_push & ~bus.rx_full & (bus.rx_data != CH_CR);

  // Two quiet cycles after each push tolerate a transmitter with a registered full flag
  assign bus.tx_push   = (state == ST_RESP) & ~bus.tx_full & (push_hist == 2'b00);
  assign bus.tx_data   = bus.tx_push ? resp_buf[23:16] : 8'hFF;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_write = write_q;
  assign bus.reg_read  = read_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      is_write  <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      bus_cnt   <= 16'd0;
      resp_buf  <= 24'd0;
      resp_cnt  <= 2'd0;
      push_hist <= 2'b00;
    end else begin
      push_hist <= {push_hist[0], bus.tx_push};
      case (state)
        ST_IDLE: if (take) begin
          if (bus.rx_data == 8'h57 || bus.rx_data == 8'h77) begin
            is_write <= 1'b1;
            state    <= ST_ADDR_HI;
          end else if (bus.rx_data == 8'h52 || bus.rx_data == 8'h72) begin
            is_write <= 1'b0;
            state    <= ST_ADDR_HI;
          end else if (!byte_lf) begin
            state <= ST_SKIP;
          end
        end
        ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO: if (take) begin
          if (byte_hex) begin
            if (state == ST_ADDR_HI || state == ST_ADDR_LO)
              addr_q <= {addr_q[3:0], byte_nib};
            else
              wdata_q <= {wdata_q[3:0], byte_nib};
            if (state == ST_ADDR_HI)      state <= ST_ADDR_LO;
            else if (state == ST_ADDR_LO) state <= is_write ? ST_DATA_HI : ST_EOL;
            else if (state == ST_DATA_HI) state <= ST_DATA_LO;
            else                          state <= ST_EOL;
          end else if (byte_lf) begin
            resp_buf <= {CH_QM, CH_LF, 8'h00};
            resp_cnt <= 2'd2;
            state    <= ST_RESP;
          end else begin
            state <= ST_SKIP;
          end
        end
        ST_EOL: if (take) begin
          if (byte_lf) begin
            bus_cnt <= 16'd0;
            write_q <= is_write;
            read_q  <= ~is_write;
            state   <= ST_BUS;
          end else begin
            state <= ST_SKIP;
          end
        end
        ST_BUS: begin
          // ack is checked first so it beats a timeout landing in the same cycle
          if (bus.reg_ack) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            state   <= ST_RESP;
            if (is_write) begin
              resp_buf <= {CH_K, CH_LF, 8'h00};
              resp_cnt <= 2'd2;
            end else begin
              resp_buf <= {hex_ascii(bus.reg_rdata[7:4]), hex_ascii(bus.reg_rdata[3:0]), CH_LF};
              resp_cnt <= 2'd3;
            end
          end else if (bus_cnt == TIMEOUT_LAST) begin
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            resp_buf <= {CH_EX, CH_LF, 8'h00};
            resp_cnt <= 2'd2;
            state    <= ST_RESP;
          end else begin
            bus_cnt <= bus_cnt + 16'd1;
          end
        end
        ST_RESP: if (bus.tx_push) begin
          resp_buf <= {resp_buf[15:0], 8'h00};
          resp_cnt <= resp_cnt - 2'd1;
          if (resp_cnt == 2'd1) state <= ST_IDLE;
        end
        ST_SKIP: if (take && byte_lf) begin
          resp_buf <= {CH_QM, CH_LF, 8'h00};
          resp_cnt <= 2'd2;
          state    <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_cmd_bridge.sv
// Scoreboard bench for rs232_cmd_bridge: a line-level command model queues the expected
// bus beats and reply bytes, and free-running monitors compare them as the DUT emits them.
module tb_rs232_cmd_bridge;
  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rs232_cmd_bridge_if bif ();
  rs232_cmd_bridge #(.BUS_TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bif));

  always #5 clock = ~clock;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         len;
  } bus_exp_t;

  logic [7:0] exp_tx[$];
  bus_exp_t   exp_bus[$];
  string      HEXS = "0123456789ABCDEF";

  int         n_vec = 0;
  int         n_bad = 0;
  int         ack_delay = 0;
  logic [7:0] rd_val = 8'h00;
  bit         jitter_en = 1'b0;
  bit         hold_full = 1'b0;
  logic       jit = 1'b0;
  int         cyc = 0;
  int         last_push = 0;
  int         n_push = 0;
  bit         have_push = 1'b0;
  bit         chk_rxfree = 1'b0;
  bit         in_req = 1'b0;
  int         req_len = 0;
  logic       cur_w = 1'b0;
  logic [7:0] cur_a = 8'h00;
  logic [7:0] cur_d = 8'h00;
  int         age = 0;
  bus_exp_t   be;
  logic [7:0] et;

  assign bif.tx_full = jitter_en ? jit : hold_full;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reply-byte and bus-beat monitor
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      in_req     = 1'b0;
      have_push  = 1'b0;
      chk_rxfree = 1'b0;
    end else begin
      if (chk_rxfree) begin
        check("rx_full_after_lf", 32'(bif.rx_full), 32'd0);
        chk_rxfree = 1'b0;
      end
      if (bif.tx_push) begin
        n_push++;
        check("tx_full_at_push", 32'(bif.tx_full), 32'd0);
        if (have_push) check("tx_gap_ge3", 32'((cyc - last_push) >= 3), 32'd1);
        have_push = 1'b1;
        last_push = cyc;
        if (exp_tx.size() == 0) begin
          check("tx_unexpected", 32'(bif.tx_data), 32'h100);
        end else begin
          et = exp_tx.pop_front();
          check("tx_data", 32'(bif.tx_data), 32'(et));
          if (exp_tx.size() == 0 && et == 8'h0A) chk_rxfree = 1'b1;
        end
      end
      if (bif.reg_write || bif.reg_read) begin
        if (!in_req) begin
          in_req  = 1'b1;
          req_len = 0;
          cur_w   = bif.reg_write;
          cur_a   = bif.reg_addr;
          cur_d   = bif.reg_wdata;
        end
        req_len++;
        check("rx_full_in_req", 32'(bif.rx_full), 32'd1);
        check("req_exclusive", 32'(bif.reg_write & bif.reg_read), 32'd0);
      end else if (in_req) begin
        in_req = 1'b0;
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", 32'(req_len), 32'd0);
        end else begin
          be = exp_bus.pop_front();
          check("bus_kind", 32'(cur_w), 32'(be.w));
          check("bus_addr", 32'(cur_a), 32'(be.a));
          if (be.w) check("bus_wdata", 32'(cur_d), 32'(be.d));
          check("bus_len", 32'(req_len), 32'(be.len));
        end
      end
    end
  end

  // Register-bus responder: acks after ack_delay request cycles (never when negative),
  // and throws in spurious acks while no request is pending.
  always @(posedge clock) begin
    #1;
    jit = ($urandom_range(0, 3) == 0);
    if (reset) begin
      bif.reg_ack   = 1'b0;
      bif.reg_rdata = 8'h00;
      age = 0;
    end else if (bif.reg_write || bif.reg_read) begin
      if (ack_delay >= 0 && age == ack_delay) begin
        bif.reg_ack   = 1'b1;
        bif.reg_rdata = rd_val;
      end else begin
        bif.reg_ack   = 1'b0;
        bif.reg_rdata = 8'($urandom);
      end
      age++;
    end else begin
      age = 0;
      bif.reg_ack   = ($urandom_range(0, 7) == 0);
      bif.reg_rdata = 8'($urandom);
    end
  end

  function automatic int hexv(input logic [7:0] c);
    for (int i = 0; i < 16; i++) begin
      if (c == 8'(HEXS[i])) return i;
      if (i >= 10 && c == 8'(HEXS[i]) + 8'h20) return i;
    end
    return -1;
  endfunction

  // Line-level reference: 0 = no reply, 1 = error, 2 = write, 3 = read
  function automatic void model(input logic [7:0] line[$], output int kind,
                                output logic [7:0] a, output logic [7:0] d);
    logic [7:0] s[$];
    int nd;
    s = {};
    foreach (line[i]) if (line[i] != 8'h0D && line[i] != 8'h0A) s.push_back(line[i]);
    kind = 1;
    a = 8'h00;
    d = 8'h00;
    if (s.size() == 0) begin
      kind = 0;
      return;
    end
    if (s[0] == 8'h57 || s[0] == 8'h77) nd = 4;
    else if (s[0] == 8'h52 || s[0] == 8'h72) nd = 2;
    else return;
    if (s.size() != nd + 1) return;
    for (int i = 1; i <= nd; i++) if (hexv(s[i]) < 0) return;
    a = 8'(hexv(s[1]) * 16 + hexv(s[2]));
    if (nd == 4) begin
      d = 8'(hexv(s[3]) * 16 + hexv(s[4]));
      kind = 2;
    end else begin
      kind = 3;
    end
  endfunction

  function automatic logic [7:0] rand_hex();
    int n;
    logic [7:0] c;
    n = int'($urandom_range(0, 15));
    c = 8'(HEXS[n]);
    if (n >= 10 && $urandom_range(0, 1) == 1) c = c + 8'h20;
    return c;
  endfunction

  function automatic void gen_line(output logic [7:0] q[$]);
    int r;
    int n;
    q = {};
    r = int'($urandom_range(0, 9));
    if (r >= 1 && r <= 2) begin
      n = int'($urandom_range(1, 6));
      repeat (n) q.push_back(8'($urandom_range(32, 126)));
    end else if (r >= 3 && r <= 6) begin
      q.push_back(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h77);
      repeat (4) q.push_back(rand_hex());
    end else if (r >= 7) begin
      q.push_back(($urandom_range(0, 1) == 1) ? 8'h52 : 8'h72);
      repeat (2) q.push_back(rand_hex());
    end
    if ($urandom_range(0, 3) == 0) q.insert(int'($urandom_range(0, q.size())), 8'h0D);
    q.push_back(8'h0A);
  endfunction

  function automatic void str2q(input string s, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_ready);
    if (expect_ready) check("rx_ready", 32'(bif.rx_full), 32'd0);
    bif.rx_data = b;
    bif.rx_push = 1'b1;
    step();
    bif.rx_push = 1'b0;
    bif.rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (exp_tx.size() == 0 && exp_bus.size() == 0 && !bif.rx_full) return;
      step();
    end
    check("idle_wait_expired", 32'(exp_tx.size() + exp_bus.size()) + 32'(bif.rx_full), 32'd0);
    exp_tx.delete();
    exp_bus.delete();
  endtask

  // mode: 0 plain, 1 poke a byte during BUS, 2 hold tx_full 50 cycles, 3 reset during request
  task automatic run_line(input logic [7:0] line[$], input int delay, input logic [7:0] rd,
                          input int mode);
    int kind;
    logic [7:0] a;
    logic [7:0] d;
    bit acked;
    bus_exp_t e;
    int n0;
    ack_delay = delay;
    rd_val    = rd;
    model(line, kind, a, d);
    acked = (delay >= 0 && delay < TO);
    if (kind == 1) begin
      exp_tx.push_back(8'h3F);
      exp_tx.push_back(8'h0A);
    end else if (kind >= 2) begin
      e.w = (kind == 2);
      e.a = a;
      e.d = d;
      e.len = acked ? delay + 1 : TO;
      exp_bus.push_back(e);
      if (!acked) begin
        exp_tx.push_back(8'h21);
      end else if (kind == 2) begin
        exp_tx.push_back(8'h4B);
      end else begin
        exp_tx.push_back(8'(HEXS[rd[7:4]]));
        exp_tx.push_back(8'(HEXS[rd[3:0]]));
      end
      exp_tx.push_back(8'h0A);
    end
    foreach (line[i]) begin
      send_byte(line[i], 1'b1);
      if (i < line.size() - 1) repeat ($urandom_range(0, 2)) step();
    end
    if (mode == 1) begin
      check("rx_full_in_bus", 32'(bif.rx_full), 32'd1);
      send_byte(8'h57, 1'b0);
    end else if (mode == 2) begin
      hold_full = 1'b1;
      n0 = n_push;
      repeat (50) step();
      check("no_push_while_full", 32'(n_push - n0), 32'd0);
      hold_full = 1'b0;
    end else if (mode == 3) begin
      check("write_before_reset", 32'(bif.reg_write), 32'd1);
      reset = 1'b1;
      #1;
      check("reset_drops_write", 32'(bif.reg_write), 32'd0);
      check("reset_rx_full", 32'(bif.rx_full), 32'd1);
      exp_tx.delete();
      exp_bus.delete();
      repeat (2) step();
      reset = 1'b0;
      #1;
      check("rx_full_after_release", 32'(bif.rx_full), 32'd0);
      step();
      return;
    end
    wait_idle(600);
  endtask

  task automatic run_s(input string s, input int delay, input logic [7:0] rd, input int mode);
    logic [7:0] q[$];
    str2q(s, q);
    run_line(q, delay, rd, mode);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    bif.rx_push = 1'b0;
    bif.rx_data = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("reset_rx_full", 32'(bif.rx_full), 32'd1);
    check("reset_tx_push", 32'(bif.tx_push), 32'd0);
    check("reset_tx_data", 32'(bif.tx_data), 32'hFF);
    check("reset_reg_write", 32'(bif.reg_write), 32'd0);
    check("reset_reg_read", 32'(bif.reg_read), 32'd0);
    check("reset_reg_addr", 32'(bif.reg_addr), 32'd0);
    check("reset_reg_wdata", 32'(bif.reg_wdata), 32'd0);
    reset = 1'b0;
    #1;
    check("rx_full_after_reset", 32'(bif.rx_full), 32'd0);
    step();

    run_s("W3cA5\n", 2, 8'h00, 0);
    run_s("R07\r\n", 0, 8'h9E, 0);
    run_s("W1Gx\n", 0, 8'h00, 0);
    run_s("RFF\n", 1, 8'($urandom), 0);
    run_s("R42\n", -1, 8'h00, 0);
    run_s("r10\n", TO - 1, 8'h5A, 0);
    run_s("w10C3\n", TO, 8'h00, 0);
    run_s("\n", 0, 8'h00, 0);
    run_s("\r\n", 0, 8'h00, 0);
    run_s("W1\n", 0, 8'h00, 0);
    run_s("R\n", 0, 8'h00, 0);
    run_s("R123\n", 0, 8'h00, 0);
    run_s("R00\n", 3, 8'h3C, 1);
    run_s("W0155\n", 0, 8'h00, 0);
    run_s("rab\n", 2, 8'hD4, 2);
    run_s("W77AA\n", -1, 8'h00, 3);
    run_s("R00\n", 0, 8'h61, 0);

    jitter_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      gen_line(q);
      run_line(q, int'($urandom_range(0, 6)) - 1, 8'($urandom), 0);
    end
    jitter_en = 1'b0;
    wait_idle(200);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
